alu_func_sequencer: RTL and testbench



---
 rtl/alu_pkg.sv | 46 ++++
 rtl/alu_func_enc.sv | 37 +++
 rtl/alu_func_sequencer.sv | 188 ++++++++++++++++++
 tb/tb_alu_func_sequencer.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: function codes, command codes, sequencer FSM encoding.
// The op-index mapping function is shared with the decoder bench.
package alu_pkg;

  localparam logic [2:0] FUNC_OP0 = 3'b000;
  localparam logic [2:0] FUNC_OP1 = 3'b011;
  localparam logic [2:0] FUNC_OP2 = 3'b100;
  localparam logic [2:0] FUNC_OP3 = 3'b101;

  localparam logic [2:0] CMD_OP0     = 3'b000;
  localparam logic [2:0] CMD_OP1     = 3'b001;
  localparam logic [2:0] CMD_OP2     = 3'b010;
  localparam logic [2:0] CMD_OP3     = 3'b011;
  localparam logic [2:0] CMD_OP1_OP0 = 3'b100;
  localparam logic [2:0] CMD_OP3_OP1 = 3'b101;
  localparam logic [2:0] CMD_ILL6    = 3'b110;
  localparam logic [2:0] CMD_ILL7    = 3'b111;

  localparam logic [1:0] OP0 = 2'd0;
  localparam logic [1:0] OP1 = 2'd1;
  localparam logic [1:0] OP2 = 2'd2;
  localparam logic [1:0] OP3 = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_BEAT1 = 2'b01,
    ST_BEAT2 = 2'b10
  } seq_state_e;

  function automatic logic [2:0] op_func(input logic [1:0] op);
    logic [2:0] code;
    case (op)
      OP0:     code = FUNC_OP0;
      OP1:     code = FUNC_OP1;
      OP2:     code = FUNC_OP2;
      OP3:     code = FUNC_OP3;
      default: code = FUNC_OP0;
    endcase
    return code;
  endfunction

  function automatic logic func_parity(input logic [2:0] code);
    return ^code;
  endfunction

endpackage

// File: rtl/alu_func_enc.sv
// Combinational command lookup: first/second function code, pair flag, illegal flag.
module alu_func_enc
  import alu_pkg::*;
(
  input  logic [2:0] cmd,
  output logic [2:0] first_code,
  output logic [2:0] second_code,
  output logic       is_pair,
  output logic       is_illegal
);

  // Command to micro-op expansion
  always_comb begin
    first_code  = FUNC_OP0;
    second_code = FUNC_OP0;
    is_pair     = 1'b0;
    is_illegal  = 1'b0;
    case (cmd)
      CMD_OP0: first_code = op_func(OP0);
      CMD_OP1: first_code = op_func(OP1);
      CMD_OP2: first_code = op_func(OP2);
      CMD_OP3: first_code = op_func(OP3);
      CMD_OP1_OP0: begin
        first_code  = op_func(OP1);
        second_code = op_func(OP0);
        is_pair     = 1'b1;
      end
      CMD_OP3_OP1: begin
        first_code  = op_func(OP3);
        second_code = op_func(OP1);
        is_pair     = 1'b1;
      end
      default: is_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_func_sequencer.sv
// ALU command sequencer: expands commands into one or two registered micro-op beats.
// Optional parity output func_par enabled by macro ALU_FUNC_SEQ_PARITY_EN.
module alu_func_sequencer
  import alu_pkg::*;
#(
  parameter int CNT_W = 8,
  parameter int ERR_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd,
  output logic             func_valid,
  input  logic             func_ready,
  output logic [2:0]       alu_func,
  output logic             last,
  output logic             illegal,
  output logic [CNT_W-1:0] issued_cnt,
  output logic [ERR_W-1:0] err_cnt
`ifdef ALU_FUNC_SEQ_PARITY_EN
  ,
  output logic             func_par
`endif
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [ERR_W-1:0] ERR_ONE = {{(ERR_W-1){1'b0}}, 1'b1};
  localparam logic [ERR_W-1:0] ERR_MAX = {ERR_W{1'b1}};

  seq_state_e       state_r, state_s;
  logic             func_valid_r, func_valid_s;
  logic [2:0]       alu_func_r, alu_func_s;
  logic             last_r, last_s;
  logic [2:0]       second_r, second_s;
  logic             illegal_r, illegal_s;
  logic [CNT_W-1:0] issued_cnt_r;
  logic [ERR_W-1:0] err_cnt_r;

  logic [2:0]       enc_first_s, enc_second_s;
  logic             enc_pair_s, enc_illegal_s;
  logic             handshake_s, accept_s, ready_s;

  alu_func_enc u_enc (
    .cmd         (cmd),
    .first_code  (enc_first_s),
    .second_code (enc_second_s),
    .is_pair     (enc_pair_s),
    .is_illegal  (enc_illegal_s)
  );

  // A final beat leaving frees the slot in the same cycle (zero bubble)
  assign handshake_s = func_valid_r & func_ready;
  assign ready_s     = (state_r == ST_IDLE) | (handshake_s & last_r);
  assign accept_s    = cmd_valid & ready_s;

  // Next-state and next-beat selection
  always_comb begin
    state_s      = state_r;
    func_valid_s = func_valid_r;
    alu_func_s   = alu_func_r;
    last_s       = last_r;
    second_s     = second_r;
    illegal_s    = 1'b0;
    if (accept_s) begin
      if (enc_illegal_s) begin
        state_s      = ST_IDLE;
        func_valid_s = 1'b0;
        illegal_s    = 1'b1;
      end else begin
        state_s      = ST_BEAT1;
        func_valid_s = 1'b1;
        alu_func_s   = enc_first_s;
        last_s       = ~enc_pair_s;
        second_s     = enc_second_s;
      end
    end else if (handshake_s) begin
      case (state_r)
        ST_BEAT1: begin
          if (!last_r) begin
            state_s    = ST_BEAT2;
            alu_func_s = second_r;
            last_s     = 1'b1;
          end else begin
            state_s      = ST_IDLE;
            func_valid_s = 1'b0;
          end
        end
        ST_BEAT2: begin
          state_s      = ST_IDLE;
          func_valid_s = 1'b0;
        end
        default: begin
          state_s      = ST_IDLE;
          func_valid_s = 1'b0;
        end
      endcase
    end else begin
      state_s = state_r;
    end
  end

  // FSM and output beat registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ST_IDLE;
      func_valid_r <= 1'b0;
      alu_func_r   <= 3'b000;
      last_r       <= 1'b0;
      second_r     <= 3'b000;
      illegal_r    <= 1'b0;
    end else begin
      state_r      <= state_s;
      func_valid_r <= func_valid_s;
      alu_func_r   <= alu_func_s;
      last_r       <= last_s;
      second_r     <= second_s;
      illegal_r    <= illegal_s;
    end
  end

  // Issued micro-op counter (wraps) and illegal command counter (saturates)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      issued_cnt_r <= {CNT_W{1'b0}};
      err_cnt_r    <= {ERR_W{1'b0}};
    end else begin
      if (handshake_s) begin
        issued_cnt_r <= issued_cnt_r + CNT_ONE;
      end
      if (accept_s && enc_illegal_s && (err_cnt_r != ERR_MAX)) begin
        err_cnt_r <= err_cnt_r + ERR_ONE;
      end
    end
  end

  assign cmd_ready  = ready_s;
  assign func_valid = func_valid_r;
  assign alu_func   = alu_func_r;
  assign last       = last_r;
  assign illegal    = illegal_r;
  assign issued_cnt = issued_cnt_r;
  assign err_cnt    = err_cnt_r;

`ifdef ALU_FUNC_SEQ_PARITY_EN
  logic par_r;

  // Parity travels with alu_func
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par_r <= 1'b0;
    end else begin
      par_r <= func_parity(alu_func_s);
    end
  end

  assign func_par = par_r;

`ifndef SYNTHESIS
  alu_func_seq_par_chk u_par_chk (
    .clk      (clk),
    .rst_n    (rst_n),
    .alu_func (alu_func_r),
    .func_par (par_r)
  );
`endif
`endif

endmodule

`ifdef ALU_FUNC_SEQ_PARITY_EN
`ifndef SYNTHESIS
// Simulation-only check that func_par always matches the held function code.
module alu_func_seq_par_chk
  import alu_pkg::*;
(
  input logic       clk,
  input logic       rst_n,
  input logic [2:0] alu_func,
  input logic       func_par
);

  a_par_match: assert property (@(posedge clk) disable iff (!rst_n)
    func_par == func_parity(alu_func));

endmodule
`endif
`endif

// File: tb/tb_alu_func_sequencer.sv
// Self-checking bench for alu_func_sequencer: vector table, directed corner sequences,
// and randomized traffic against a queue-based reference model.
module tb_alu_func_sequencer;

  logic       clk;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd;
  logic       func_valid;
  logic       func_ready;
  logic [2:0] alu_func;
  logic       last;
  logic       illegal;
  logic [7:0] issued_cnt;
  logic [3:0] err_cnt;

  int total;
  int bad;

  alu_func_sequencer #(.CNT_W(8), .ERR_W(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd        (cmd),
    .func_valid (func_valid),
    .func_ready (func_ready),
    .alu_func   (alu_func),
    .last       (last),
    .illegal    (illegal),
    .issued_cnt (issued_cnt),
    .err_cnt    (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] code;
    logic       lst;
  } beat_t;

  typedef struct {
    logic [2:0] cmd;
    logic [2:0] first;
    logic [2:0] second;
    logic       ill;
    int         beats;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n      = 1'b0;
    cmd_valid  = 1'b0;
    cmd        = 3'b000;
    func_ready = 1'b0;
    @(negedge clk);
    chk("rst func_valid", 32'(func_valid), 32'd0);
    chk("rst alu_func", 32'(alu_func), 32'd0);
    chk("rst last", 32'(last), 32'd0);
    chk("rst illegal", 32'(illegal), 32'd0);
    chk("rst issued_cnt", 32'(issued_cnt), 32'd0);
    chk("rst err_cnt", 32'(err_cnt), 32'd0);
    chk("rst cmd_ready", 32'(cmd_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  // Reference expansion of a command into beats, straight from the command map
  function automatic void expand(input logic [2:0] c, output beat_t b[$], output logic ill);
    b   = {};
    ill = 1'b0;
    case (c)
      3'b000: b.push_back('{3'b000, 1'b1});
      3'b001: b.push_back('{3'b011, 1'b1});
      3'b010: b.push_back('{3'b100, 1'b1});
      3'b011: b.push_back('{3'b101, 1'b1});
      3'b100: begin b.push_back('{3'b011, 1'b0}); b.push_back('{3'b000, 1'b1}); end
      3'b101: begin b.push_back('{3'b101, 1'b0}); b.push_back('{3'b011, 1'b1}); end
      default: ill = 1'b1;
    endcase
  endfunction

  vec_t  tbl[8];
  beat_t q[$];
  beat_t nb[$];
  logic  nill;
  logic  exp_ready, exp_illegal;
  logic [2:0] hold;
  int    exp_issued, exp_err;

  initial begin
    total = 0;
    bad   = 0;
    tbl[0] = '{3'b000, 3'b000, 3'b000, 1'b0, 1};
    tbl[1] = '{3'b001, 3'b011, 3'b000, 1'b0, 1};
    tbl[2] = '{3'b010, 3'b100, 3'b000, 1'b0, 1};
    tbl[3] = '{3'b011, 3'b101, 3'b000, 1'b0, 1};
    tbl[4] = '{3'b100, 3'b011, 3'b000, 1'b0, 2};
    tbl[5] = '{3'b101, 3'b101, 3'b011, 1'b0, 2};
    tbl[6] = '{3'b110, 3'b000, 3'b000, 1'b1, 0};
    tbl[7] = '{3'b111, 3'b000, 3'b000, 1'b1, 0};

    do_reset();

    // Table: one command at a time, held for a cycle, then drained
    for (int i = 0; i < 8; i++) begin
      cmd_valid  = 1'b1;
      cmd        = tbl[i].cmd;
      func_ready = 1'b0;
      tick();
      cmd_valid = 1'b0;
      chk("tbl illegal", 32'(illegal), 32'(tbl[i].ill));
      chk("tbl func_valid", 32'(func_valid), 32'(!tbl[i].ill));
      if (!tbl[i].ill) begin
        chk("tbl first code", 32'(alu_func), 32'(tbl[i].first));
        chk("tbl first last", 32'(last), 32'(tbl[i].beats == 1));
        func_ready = 1'b1;
        tick();
        if (tbl[i].beats == 2) begin
          chk("tbl second code", 32'(alu_func), 32'(tbl[i].second));
          chk("tbl second last", 32'(last), 32'd1);
          tick();
        end
        chk("tbl drained", 32'(func_valid), 32'd0);
      end else begin
        tick();
        chk("tbl illegal clear", 32'(illegal), 32'd0);
      end
    end

    do_reset();

    // Single command, 1-cycle latency, counter one cycle later
    cmd_valid = 1'b1; cmd = 3'b001; func_ready = 1'b1;
    tick();
    cmd_valid = 1'b0;
    chk("A code", 32'(alu_func), 32'h3);
    chk("A valid", 32'(func_valid), 32'd1);
    chk("A last", 32'(last), 32'd1);
    chk("A issued before", 32'(issued_cnt), 32'd0);
    tick();
    chk("A issued", 32'(issued_cnt), 32'd1);
    chk("A idle", 32'(func_valid), 32'd0);
    chk("A retain", 32'(alu_func), 32'h3);

    // Pair 100 with ready high
    cmd_valid = 1'b1; cmd = 3'b100;
    #1;
    chk("B ready idle", 32'(cmd_ready), 32'd1);
    tick();
    cmd_valid = 1'b0;
    #1;
    chk("B beat1 code", 32'(alu_func), 32'h3);
    chk("B beat1 last", 32'(last), 32'd0);
    chk("B beat1 ready", 32'(cmd_ready), 32'd0);
    tick();
    chk("B beat2 code", 32'(alu_func), 32'h0);
    chk("B beat2 last", 32'(last), 32'd1);
    chk("B beat2 valid", 32'(func_valid), 32'd1);
    tick();
    chk("B issued", 32'(issued_cnt), 32'd3);

    // Pair 101 stalled for three cycles
    cmd_valid = 1'b1; cmd = 3'b101; func_ready = 1'b0;
    tick();
    cmd_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("C hold code", 32'(alu_func), 32'h5);
      chk("C hold last", 32'(last), 32'd0);
      chk("C hold ready", 32'(cmd_ready), 32'd0);
      tick();
    end
    func_ready = 1'b1;
    #1;
    chk("C ready beat1", 32'(cmd_ready), 32'd0);
    tick();
    chk("C beat2 code", 32'(alu_func), 32'h3);
    chk("C beat2 last", 32'(last), 32'd1);
    tick();
    chk("C issued", 32'(issued_cnt), 32'd5);

    // Back-to-back singles without a bubble
    cmd_valid = 1'b1; cmd = 3'b010;
    tick();
    chk("D first", 32'(alu_func), 32'h4);
    cmd = 3'b011;
    #1;
    chk("D ready on last", 32'(cmd_ready), 32'd1);
    tick();
    cmd_valid = 1'b0;
    chk("D second", 32'(alu_func), 32'h5);
    chk("D valid", 32'(func_valid), 32'd1);
    tick();
    chk("D issued", 32'(issued_cnt), 32'd7);

    // Illegal command seventeen times: err_cnt saturates at 15
    cmd_valid = 1'b1; cmd = 3'b110;
    for (int i = 0; i < 17; i++) begin
      tick();
      chk("E illegal", 32'(illegal), 32'd1);
      chk("E valid", 32'(func_valid), 32'd0);
      chk("E err", 32'(err_cnt), 32'((i + 1 > 15) ? 15 : i + 1));
    end
    cmd_valid = 1'b0;
    tick();
    chk("E illegal clear", 32'(illegal), 32'd0);
    chk("E err sat", 32'(err_cnt), 32'd15);

    // Asynchronous reset during the first beat of a pair
    cmd_valid = 1'b1; cmd = 3'b100; func_ready = 1'b0;
    tick();
    cmd_valid = 1'b0;
    chk("F beat1", 32'(alu_func), 32'h3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("F async valid", 32'(func_valid), 32'd0);
    chk("F async code", 32'(alu_func), 32'd0);
    func_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("F no beat2", 32'(func_valid), 32'd0);
      chk("F idle ready", 32'(cmd_ready), 32'd1);
    end

    // Randomized traffic against the queue model
    do_reset();
    q = {};
    hold = 3'b000;
    exp_issued = 0;
    exp_err = 0;
    exp_illegal = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      chk("R func_valid", 32'(func_valid), 32'(q.size() != 0));
      if (q.size() != 0) begin
        hold = q[0].code;
        chk("R alu_func", 32'(alu_func), 32'(q[0].code));
        chk("R last", 32'(last), 32'(q[0].lst));
      end else begin
        chk("R alu_func hold", 32'(alu_func), 32'(hold));
      end
      chk("R illegal", 32'(illegal), 32'(exp_illegal));
      chk("R issued_cnt", 32'(issued_cnt), 32'(exp_issued & 255));
      chk("R err_cnt", 32'(err_cnt), 32'(exp_err));

      cmd_valid  = ($urandom_range(0, 3) != 0);
      cmd        = 3'($urandom_range(0, 7));
      func_ready = ($urandom_range(0, 3) != 0);
      #1;
      exp_ready = (q.size() == 0) || (q.size() == 1 && func_ready);
      chk("R cmd_ready", 32'(cmd_ready), 32'(exp_ready));

      exp_illegal = 1'b0;
      if (q.size() != 0 && func_ready) begin
        void'(q.pop_front());
        exp_issued++;
      end
      if (cmd_valid && exp_ready) begin
        expand(cmd, nb, nill);
        if (nill) begin
          exp_illegal = 1'b1;
          if (exp_err < 15) exp_err++;
        end else begin
          q = nb;
        end
      end
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
